// File: rtl/branch_predict_tournament.sv
// Tournament chooser: a 2-bit choice table (CPHT) picks between the local and
// global direction predictors in F, the choice context rides F->D->E->M, and
// at M both predictors are scored to train the table and count mispredictions.
module branch_predict_tournament #(
  parameter int CPHT_DEPTH = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flushD,
  input  logic                 flushE,
  input  logic                 flushM,
  input  logic                 stallD,
  input  logic [31:0]          pcF,
  input  logic                 branchF,
  input  logic                 local_predF,
  input  logic                 global_predF,
  input  logic                 branchM,
  input  logic                 actual_takeM,
  output logic                 pred_takeD,
  output logic                 choose_globalD,
  output logic                 correctM,
  output logic                 mispredM,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << CPHT_DEPTH;

  // Per-branch prediction context carried down the pipeline.
  typedef struct packed {
    logic                  pred_take;
    logic                  sel;
    logic                  local_pred;
    logic                  global_pred;
    logic [CPHT_DEPTH-1:0] idx;
  } ctx_t;

  logic [1:0]            cpht_q [ENTRIES];
  logic [1:0]            entry_d;
  logic [1:0]            entry_cur_s;
  logic [CPHT_DEPTH-1:0] idx_f_s;
  ctx_t                  ctx_f_s;
  ctx_t                  ctx_d_q, ctx_d_d;
  ctx_t                  ctx_e_q, ctx_e_d;
  ctx_t                  ctx_m_q, ctx_m_d;
  logic                  lc_s, gc_s;
  logic                  train_up_s, train_dn_s, cpht_we_s;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic                  unused_pc_s;

  // Word-aligned PC bits form the table index; the rest of the PC is ignored.
  assign idx_f_s     = pcF[CPHT_DEPTH+1:2];
  assign unused_pc_s = ^{pcF[31:CPHT_DEPTH+2], pcF[1:0]};

  // F-stage selection: the table MSB picks the global predictor.
  always_comb begin
    ctx_f_s.idx         = idx_f_s;
    ctx_f_s.sel         = cpht_q[idx_f_s][1];
    ctx_f_s.local_pred  = local_predF;
    ctx_f_s.global_pred = global_predF;
    if (ctx_f_s.sel) begin
      ctx_f_s.pred_take = branchF & global_predF;
    end else begin
      ctx_f_s.pred_take = branchF & local_predF;
    end
  end

  // Pipeline next-state: flush clears a stage and wins over stall at D.
  always_comb begin
    if (flushD) begin
      ctx_d_d = '0;
    end else if (stallD) begin
      ctx_d_d = ctx_d_q;
    end else begin
      ctx_d_d = ctx_f_s;
    end
    if (flushE) begin
      ctx_e_d = '0;
    end else begin
      ctx_e_d = ctx_d_q;
    end
    if (flushM) begin
      ctx_m_d = '0;
    end else begin
      ctx_m_d = ctx_e_q;
    end
  end

  // M-stage scoring of the final prediction and of each component predictor.
  always_comb begin
    lc_s       = (ctx_m_q.local_pred == actual_takeM);
    gc_s       = (ctx_m_q.global_pred == actual_takeM);
    correctM   = branchM & (ctx_m_q.pred_take == actual_takeM);
    mispredM   = branchM & ~correctM;
    train_up_s = branchM & gc_s & ~lc_s;
    train_dn_s = branchM & lc_s & ~gc_s;
    cpht_we_s  = train_up_s | train_dn_s;
  end

  // Saturating 2-bit update of the entry carried down with the branch.
  always_comb begin
    entry_cur_s = cpht_q[ctx_m_q.idx];
    if (train_up_s && (entry_cur_s != 2'b11)) begin
      entry_d = entry_cur_s + 2'b01;
    end else if (train_dn_s && (entry_cur_s != 2'b00)) begin
      entry_d = entry_cur_s - 2'b01;
    end else begin
      entry_d = entry_cur_s;
    end
  end

  // Statistics counters, wrapping naturally at their width.
  always_comb begin
    if (branchM) begin
      branch_cnt_d = branch_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if (mispredM) begin
      mispred_cnt_d = mispred_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // Choice table: reset to weakly-local; F reads see the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cpht_q[i] <= 2'b01;
      end
    end else if (cpht_we_s) begin
      cpht_q[ctx_m_q.idx] <= entry_d;
    end
  end

  // Context pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_d_q       <= '0;
      ctx_e_q       <= '0;
      ctx_m_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ctx_d_q       <= ctx_d_d;
      ctx_e_q       <= ctx_e_d;
      ctx_m_q       <= ctx_m_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pred_takeD     = ctx_d_q.pred_take;
  assign choose_globalD = ctx_d_q.sel;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Self-checking bench for branch_predict_tournament: directed scenarios plus a
// randomized run against a behavioural model of the tournament chooser.
module tb_branch_predict_tournament;

  logic        clk = 1'b0;
  logic        rst, flushD, flushE, flushM, stallD;
  logic [31:0] pcF;
  logic        branchF, local_predF, global_predF, branchM, actual_takeM;
  logic        pred_takeD, choose_globalD, correctM, mispredM;
  logic [31:0] branch_cnt, mispred_cnt;
  logic        s_pred_takeD, s_choose_globalD, s_correctM, s_mispredM;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_predict_tournament dut (
    .clk(clk), .rst(rst), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .stallD(stallD), .pcF(pcF), .branchF(branchF), .local_predF(local_predF),
    .global_predF(global_predF), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(pred_takeD), .choose_globalD(choose_globalD), .correctM(correctM),
    .mispredM(mispredM), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

  branch_predict_tournament #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .stallD(stallD), .pcF(pcF), .branchF(branchF), .local_predF(local_predF),
    .global_predF(global_predF), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(s_pred_takeD), .choose_globalD(s_choose_globalD), .correctM(s_correctM),
    .mispredM(s_mispredM), .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt));

  always #5 clk = ~clk;

  // Behavioural model: table of choice counters, three in-flight contexts.
  typedef struct {
    bit pt;
    bit sel;
    bit lp;
    bit gp;
    int idx;
  } mctx_t;

  int        tbl [64];
  mctx_t     md, me, mm;
  bit [31:0] m_bcnt, m_mcnt;

  function automatic bit model_correct();
    return branchM && (mm.pt == actual_takeM);
  endfunction

  // Apply current inputs for one clock, advancing the model in step.
  task automatic tick();
    mctx_t f, z;
    bit    lc, gc;
    z = '{pt: 0, sel: 0, lp: 0, gp: 0, idx: 0};
    if (rst) begin
      for (int i = 0; i < 64; i++) tbl[i] = 1;
      md = z; me = z; mm = z; m_bcnt = 0; m_mcnt = 0;
    end else begin
      f.idx = (pcF >> 2) % 64;
      f.sel = (tbl[f.idx] >= 2);
      f.lp  = local_predF;
      f.gp  = global_predF;
      f.pt  = branchF && (f.sel ? global_predF : local_predF);
      if (branchM) begin
        lc = (mm.lp == actual_takeM);
        gc = (mm.gp == actual_takeM);
        if (gc && !lc) tbl[mm.idx] = (tbl[mm.idx] + 1 > 3) ? 3 : tbl[mm.idx] + 1;
        else if (lc && !gc) tbl[mm.idx] = (tbl[mm.idx] - 1 < 0) ? 0 : tbl[mm.idx] - 1;
        m_bcnt = m_bcnt + 1;
        if (!model_correct()) m_mcnt = m_mcnt + 1;
      end
      mm = flushM ? z : me;
      me = flushE ? z : md;
      md = flushD ? z : (stallD ? md : f);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flushD = 0; flushE = 0; flushM = 0; stallD = 0;
    pcF = 32'h0; branchF = 0; local_predF = 0; global_predF = 0;
    branchM = 0; actual_takeM = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
    branchF = 1; pcF = 32'h40; local_predF = 1; global_predF = 0;
    tick();
    n_checks++; if (pred_takeD !== 1'b1) begin n_errors++; $display("FAIL reset_pred_takeD got %b want 1", pred_takeD); end
    n_checks++; if (choose_globalD !== 1'b0) begin n_errors++; $display("FAIL reset_choose_global got %b want 0", choose_globalD); end
    n_checks++; if (branch_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_branch_cnt got %0d want 0", branch_cnt); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_mispred_cnt got %0d want 0", mispred_cnt); end
    // After reset the M context is empty, so correctM = branchM & ~actual.
    branchF = 0; branchM = 1; actual_takeM = 0; #1;
    n_checks++; if (correctM !== 1'b1) begin n_errors++; $display("FAIL reset_correctM_nt got %b want 1", correctM); end
    actual_takeM = 1; #1;
    n_checks++; if (mispredM !== 1'b1) begin n_errors++; $display("FAIL reset_mispredM_t got %b want 1", mispredM); end
    branchM = 0; actual_takeM = 0;
  endtask

  task automatic test_train_global();
    for (int c = 0; c < 6; c++) begin
      pcF = 32'h40; branchF = (c < 3); local_predF = 0; global_predF = 1;
      branchM = (c >= 3); actual_takeM = 1; #1;
      if (c >= 3) begin
        n_checks++; if (mispredM !== 1'b1) begin n_errors++; $display("FAIL train_mispredM c=%0d got %b want 1", c, mispredM); end
      end
      tick();
      if (c >= 3) begin
        n_checks++;
        if (choose_globalD !== (c != 3)) begin
          n_errors++; $display("FAIL train_choose c=%0d got %b want %b", c, choose_globalD, (c != 3));
        end
      end
    end
    branchM = 0;
    n_checks++; if (branch_cnt !== 32'd3) begin n_errors++; $display("FAIL train_branch_cnt got %0d want 3", branch_cnt); end
    n_checks++; if (mispred_cnt !== 32'd3) begin n_errors++; $display("FAIL train_mispred_cnt got %0d want 3", mispred_cnt); end
    branchF = 1; local_predF = 1; global_predF = 0; tick();
    n_checks++; if (choose_globalD !== 1'b1) begin n_errors++; $display("FAIL train_lookup_choose got %b want 1", choose_globalD); end
    n_checks++; if (pred_takeD !== 1'b0) begin n_errors++; $display("FAIL train_lookup_pred0 got %b want 0", pred_takeD); end
    global_predF = 1; tick();
    n_checks++; if (pred_takeD !== 1'b1) begin n_errors++; $display("FAIL train_lookup_pred1 got %b want 1", pred_takeD); end
    branchF = 0;
  endtask

  task automatic test_no_train_agree();
    logic [31:0] mc;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 4; c++) begin
        pcF = 32'h80; branchF = (c == 0); local_predF = 0; global_predF = (pass == 1);
        branchM = (c == 3); actual_takeM = 1; #1;
        if (c == 3 && pass == 0) begin
          mc = mispred_cnt;
          n_checks++; if (mispredM !== 1'b1) begin n_errors++; $display("FAIL agree_mispredM got %b want 1", mispredM); end
        end
        tick();
        if (c == 3 && pass == 0) begin
          n_checks++; if (mispred_cnt !== mc + 32'd1) begin n_errors++; $display("FAIL agree_mispred_cnt got %0d want %0d", mispred_cnt, mc + 32'd1); end
        end
      end
      branchM = 0; branchF = 1; tick();
      n_checks++;
      if (choose_globalD !== (pass == 1)) begin
        n_errors++; $display("FAIL agree_choose pass=%0d got %b want %b", pass, choose_globalD, (pass == 1));
      end
    end
    branchF = 0;
  endtask

  task automatic test_stall_flush();
    pcF = 32'h40; branchF = 1; local_predF = 0; global_predF = 1; tick();
    n_checks++; if (pred_takeD !== 1'b1 || choose_globalD !== 1'b1) begin n_errors++; $display("FAIL stall_pre got %b%b want 11", pred_takeD, choose_globalD); end
    stallD = 1;
    for (int c = 0; c < 2; c++) begin
      pcF = 32'h4 * c; global_predF = 0; tick();
      n_checks++; if (pred_takeD !== 1'b1 || choose_globalD !== 1'b1) begin n_errors++; $display("FAIL stall_hold c=%0d got %b%b want 11", c, pred_takeD, choose_globalD); end
    end
    flushD = 1; tick();
    n_checks++; if (pred_takeD !== 1'b0 || choose_globalD !== 1'b0) begin n_errors++; $display("FAIL flush_stall got %b%b want 00", pred_takeD, choose_globalD); end
    flushD = 0; stallD = 0; flushM = 1; tick(); flushM = 0; branchF = 0;
    branchM = 1; actual_takeM = 0; #1;
    n_checks++; if (correctM !== 1'b1 || mispredM !== 1'b0) begin n_errors++; $display("FAIL flushM_nt got %b%b want 10", correctM, mispredM); end
    actual_takeM = 1; #1;
    n_checks++; if (correctM !== 1'b0 || mispredM !== 1'b1) begin n_errors++; $display("FAIL flushM_t got %b%b want 01", correctM, mispredM); end
    branchM = 0; actual_takeM = 0;
  endtask

  task automatic test_collision();
    for (int c = 0; c < 5; c++) begin
      pcF = (c == 0 || c >= 3) ? 32'h14 : 32'h0;
      branchF = (c == 0 || c >= 3);
      local_predF = (c != 0); global_predF = (c == 0);
      branchM = (c == 3); actual_takeM = 1;
      tick();
      if (c >= 3) begin
        n_checks++;
        if (choose_globalD !== (c == 4) || pred_takeD !== (c == 3)) begin
          n_errors++; $display("FAIL collision c=%0d got sel=%b pt=%b want sel=%b pt=%b", c, choose_globalD, pred_takeD, (c == 4), (c == 3));
        end
      end
    end
    branchM = 0; branchF = 0;
  endtask

  task automatic test_counter_wrap();
    idle_inputs(); rst = 1; tick(); rst = 0;
    branchM = 1;
    for (int c = 0; c < 17; c++) begin
      actual_takeM = 1'($urandom_range(0, 1)); tick();
    end
    branchM = 0;
    n_checks++; if (s_branch_cnt !== 4'd1) begin n_errors++; $display("FAIL wrap_branch_cnt4 got %0d want 1", s_branch_cnt); end
    n_checks++; if (branch_cnt !== 32'd17) begin n_errors++; $display("FAIL wrap_branch_cnt32 got %0d want 17", branch_cnt); end
    n_checks++; if (s_mispred_cnt !== 4'(m_mcnt)) begin n_errors++; $display("FAIL wrap_mispred_cnt4 got %0d want %0d", s_mispred_cnt, 4'(m_mcnt)); end
  endtask

  task automatic test_random();
    bit exp_c;
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      flushD       = ($urandom_range(0, 15) == 0);
      flushE       = ($urandom_range(0, 15) == 0);
      flushM       = ($urandom_range(0, 15) == 0);
      stallD       = ($urandom_range(0, 7) == 0);
      pcF          = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 12);
      branchF      = 1'($urandom_range(0, 1));
      local_predF  = 1'($urandom_range(0, 1));
      global_predF = 1'($urandom_range(0, 1));
      branchM      = 1'($urandom_range(0, 1));
      actual_takeM = 1'($urandom_range(0, 1));
      #1;
      exp_c = model_correct();
      n_checks++;
      if (correctM !== exp_c || mispredM !== (branchM && !exp_c)) begin
        n_errors++; $display("FAIL rand_scoreM n=%0d got %b%b want %b%b", n, correctM, mispredM, exp_c, (branchM && !exp_c));
      end
      tick();
      n_checks++;
      if (pred_takeD !== md.pt || choose_globalD !== md.sel) begin
        n_errors++; $display("FAIL rand_D n=%0d got pt=%b sel=%b want pt=%b sel=%b", n, pred_takeD, choose_globalD, md.pt, md.sel);
      end
      n_checks++;
      if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt || s_branch_cnt !== 4'(m_bcnt) || s_mispred_cnt !== 4'(m_mcnt)) begin
        n_errors++; $display("FAIL rand_cnt n=%0d got %0d/%0d want %0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_train_global();
    test_no_train_agree();
    test_stall_flush();
    test_collision();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
